// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter_checker monitor: FSM state encodings.
package counter_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } chk_state_e;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Saturating up-counter with priority synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         res,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Monitor for a free-running counter: locks after LOCK_CNT good increments,
// then flags each broken step and keeps a saturating error tally.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERRW     = 8
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [ERRW-1:0]  err_cnt,
    output logic [WIDTH-1:0] expect_q
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_VAL = GW'(LOCK_CNT);

    chk_state_e       state, state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_inc;
    logic [GW-1:0]    good, good_nxt;
    logic             match;
    logic             err_evt;

    // Modulo-2^WIDTH compare: the top value wrapping to zero counts as a match.
    assign prev_inc = prev + 1'b1;
    assign match    = (q_in == prev_inc);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        err_evt   = 1'b0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_SYNC;
                    good_nxt  = '0;
                end
                ST_SYNC: begin
                    if (match) begin
                        good_nxt = good + 1'b1;
                        if (good_nxt == LOCK_VAL) state_nxt = ST_LOCK;
                    end else begin
                        good_nxt = '0;
                    end
                end
                ST_LOCK: begin
                    if (!match) begin
                        err_evt   = 1'b1;
                        good_nxt  = '0;
                        state_nxt = ST_SYNC;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state    <= ST_IDLE;
            prev     <= '0;
            good     <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            expect_q <= '0;
        end else begin
            state  <= state_nxt;
            good   <= good_nxt;
            locked <= (state_nxt == ST_LOCK);
            err    <= err_evt;
            // prev follows every enabled sample so a broken sequence is re-acquired.
            if (en) begin
                prev     <= q_in;
                expect_q <= q_in + 1'b1;
            end
        end
    end

    sat_counter #(.W(ERRW)) u_err_cnt (
        .ck  (ck),
        .res (res),
        .inc (err_evt),
        .clr (clr_err),
        .cnt (err_cnt)
    );

endmodule
